// File: rtl/nvdla_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among N_REQ requesters.
// An in-order ID FIFO routes each response back to the requester that issued it.
module nvdla_tcdm_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  localparam int IW     = $clog2(N_REQ),
  localparam int CW     = $clog2(MAX_OUT + 1),
  localparam int BW     = DATA_W / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [N_REQ-1:0]               in_req_i,
  output logic [N_REQ-1:0]               in_gnt_o,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   in_add_i,
  input  logic [N_REQ-1:0]               in_wen_i,
  input  logic [N_REQ-1:0][BW-1:0]       in_be_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   in_data_i,
  output logic [DATA_W-1:0]              in_r_data_o,
  output logic [N_REQ-1:0]               in_r_valid_o,
  output logic                           out_req_o,
  output logic [ADDR_W-1:0]              out_add_o,
  output logic                           out_wen_o,
  output logic [BW-1:0]                  out_be_o,
  output logic [DATA_W-1:0]              out_data_o,
  input  logic                           out_gnt_i,
  input  logic [DATA_W-1:0]              out_r_data_i,
  input  logic                           out_r_valid_i,
  output logic [CW-1:0]                  outstanding_o,
  output logic                           err_o
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0] ptr, lidx, sel, nxt_ptr, head;
  logic          lock, any_req, full, issue, stall, pop;
  logic [IW-1:0] id_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          err;

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Selection: a stalled requester keeps the port; otherwise search upward from ptr.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    int            c;
    sel   = ptr;
    found = 1'b0;
    cand  = '0;
    c     = 0;
    if (lock && in_req_i[lidx]) begin
      sel   = lidx;
      found = 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= N_REQ) c = c - N_REQ;
      cand = IW'(c);
      if (!found && in_req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req   = |in_req_i;
  assign full      = (count == CW'(MAX_OUT));
  assign out_req_o = any_req & ~full;
  assign issue     = out_req_o & out_gnt_i;
  assign stall     = out_req_o & ~out_gnt_i;
  assign in_gnt_o  = issue ? (ONE_HOT0 << sel) : '0;
  assign nxt_ptr   = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    if (any_req) begin
      out_add_o  = in_add_i[sel];
      out_wen_o  = in_wen_i[sel];
      out_be_o   = in_be_i[sel];
      out_data_o = in_data_i[sel];
    end
  end

  // Response routing from the registered FIFO head.
  assign pop           = out_r_valid_i & (count != '0);
  assign head          = id_mem[rd_ptr];
  assign in_r_valid_o  = pop ? (ONE_HOT0 << head) : '0;
  assign in_r_data_o   = out_r_data_i;
  assign outstanding_o = count;
  assign err_o         = err;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr    <= '0;
      lock   <= 1'b0;
      lidx   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (issue) begin
        ptr    <= nxt_ptr;
        lock   <= 1'b0;
        wr_ptr <= fifo_inc(wr_ptr);
      end else if (stall) begin
        lock <= 1'b1;
        lidx <= sel;
      end else begin
        lock <= 1'b0;
      end
      if (pop) rd_ptr <= fifo_inc(rd_ptr);
      if (out_r_valid_i && (count == '0)) err <= 1'b1;
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ID storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (issue) id_mem[wr_ptr] <= sel;
  end

endmodule
